number_source: RTL and testbench

- Upstream stage of the 6-bit up/down display counter. Produces the `number` operand that the counter consumes.
- Takes raw pushbuttons and slide switches from the board. Synchronises and debounces the buttons.
- Loads the switch value on a LOAD press and decrements the held value on each DEC press.
- Drives a registered N-bit `number` plus status strobes.

---
 rtl/number_source_pkg.sv | 15 +
 rtl/number_source_debounce.sv | 79 +++++++
 rtl/number_source.sv | 69 ++++++
 tb/tb_number_source.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/number_source_pkg.sv
// Shared types and defaults for the number_source stage.
// Debounce FSM encoding and default settle time live here.
package number_source_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  // 5 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/number_source_debounce.sv
// Two-FF synchroniser plus debounce FSM for one pushbutton.
// Emits a single-clock press per accepted low-to-high transition.
import number_source_pkg::*;

module debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          s;
  db_state_t     state;
  db_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      meta  <= raw;
      s     <= meta;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt stops at CMAX, so it never wraps
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press    = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
        end else if (cnt == CMAX) begin
          state_nx = PRESSED;
          press    = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nx = PRESSED;
        end else if (cnt == CMAX) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/number_source.sv
// Operand source for the display counter: LOAD/DEC buttons
// drive a registered number with changed/underflow strobes.
import number_source_pkg::*;

module number_source #(
  parameter int             N               = 6,
  parameter int             DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [N-1:0]   INIT_VALUE      = N'('h13)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] switches,
  input  logic         btn_load,
  input  logic         btn_dec,
  output logic [N-1:0] number,
  output logic         number_changed,
  output logic         underflow
);

  logic load_press;
  logic dec_press;
  logic chg_q;
  logic uf_q;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_load (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_load),
    .press(load_press)
  );

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dec (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_dec),
    .press(dec_press)
  );

  // strobes trail the number update by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      number         <= INIT_VALUE;
      chg_q          <= 1'b0;
      uf_q           <= 1'b0;
      number_changed <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      number_changed <= chg_q;
      underflow      <= uf_q;
      if (load_press) begin
        number <= switches;
        chg_q  <= 1'b1;
        uf_q   <= 1'b0;
      end else if (dec_press) begin
        number <= number - N'(1);
        chg_q  <= 1'b1;
        uf_q   <= (number == '0);
      end else begin
        chg_q <= 1'b0;
        uf_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_number_source.sv
// Directed bench for number_source with a short debounce window.
// Inputs change 2 time units after a rising edge.
module tb_number_source;

  logic       clk;
  logic       reset;
  logic [5:0] switches;
  logic       btn_load;
  logic       btn_dec;
  logic [5:0] number;
  logic       number_changed;
  logic       underflow;

  int errors = 0;
  int checks = 0;
  int nc_cnt = 0;
  int uf_cnt = 0;

  number_source #(
    .N(6),
    .DEBOUNCE_CYCLES(4),
    .INIT_VALUE(6'h13)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .switches      (switches),
    .btn_load      (btn_load),
    .btn_dec       (btn_dec),
    .number        (number),
    .number_changed(number_changed),
    .underflow     (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(negedge clk) begin
    if (number_changed) nc_cnt++;
    if (underflow) uf_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit ld, input bit dc, input int hold);
    btn_load = ld;
    btn_dec  = dc;
    tick(hold);
    btn_load = 1'b0;
    btn_dec  = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    checks++;
    if (number !== 6'h13) begin
      errors++;
      $display("FAIL reset_number: got %h want 13", number);
    end
    checks++;
    if (number_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_changed: got %b want 0", number_changed);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_underflow: got %b want 0", underflow);
    end
    reset  = 1'b1;
    nc_cnt = 0;
    tick(20);
    checks++;
    if (number !== 6'h13) begin
      errors++;
      $display("FAIL idle_number: got %h want 13", number);
    end
    checks++;
    if (nc_cnt !== 0) begin
      errors++;
      $display("FAIL idle_changed: got %0d pulses want 0", nc_cnt);
    end
  endtask

  task automatic test_load;
    int chg_edge;
    int nc_edge;
    chg_edge = 0;
    nc_edge  = 0;
    switches = 6'h2A;
    nc_cnt   = 0;
    btn_load = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (number == 6'h2A && chg_edge == 0) chg_edge = k;
      if (number_changed && nc_edge == 0) nc_edge = k;
    end
    #1;
    btn_load = 1'b0;
    tick(10);
    checks++;
    if (chg_edge !== 7) begin
      errors++;
      $display("FAIL load_latency: got edge %0d want 7", chg_edge);
    end
    checks++;
    if (nc_edge !== 8) begin
      errors++;
      $display("FAIL load_changed_edge: got edge %0d want 8", nc_edge);
    end
    checks++;
    if (nc_cnt !== 1) begin
      errors++;
      $display("FAIL load_pulses: got %0d want 1", nc_cnt);
    end
    checks++;
    if (number !== 6'h2A) begin
      errors++;
      $display("FAIL load_value: got %h want 2a", number);
    end
  endtask

  task automatic test_bounce;
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    nc_cnt = 0;
    uf_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      btn_dec = pat[i];
      tick(1);
    end
    press(1'b0, 1'b1, 8);
    checks++;
    if (number !== 6'h29) begin
      errors++;
      $display("FAIL bounce_value: got %h want 29", number);
    end
    checks++;
    if (nc_cnt !== 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d want 1", nc_cnt);
    end
    checks++;
    if (uf_cnt !== 0) begin
      errors++;
      $display("FAIL bounce_underflow: got %0d want 0", uf_cnt);
    end
    nc_cnt = 0;
    press(1'b0, 1'b1, 3);
    checks++;
    if (number !== 6'h29) begin
      errors++;
      $display("FAIL glitch_value: got %h want 29", number);
    end
    checks++;
    if (nc_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d want 0", nc_cnt);
    end
  endtask

  task automatic test_underflow;
    switches = 6'h01;
    press(1'b1, 1'b0, 8);
    uf_cnt = 0;
    press(1'b0, 1'b1, 8);
    checks++;
    if (number !== 6'h00) begin
      errors++;
      $display("FAIL dec_to_zero: got %h want 00", number);
    end
    checks++;
    if (uf_cnt !== 0) begin
      errors++;
      $display("FAIL dec_to_zero_uf: got %0d want 0", uf_cnt);
    end
    nc_cnt = 0;
    press(1'b0, 1'b1, 8);
    checks++;
    if (number !== 6'h3F) begin
      errors++;
      $display("FAIL wrap_value: got %h want 3f", number);
    end
    checks++;
    if (uf_cnt !== 1) begin
      errors++;
      $display("FAIL wrap_uf: got %0d clocks want 1", uf_cnt);
    end
    checks++;
    if (nc_cnt !== 1) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d want 1", nc_cnt);
    end
  endtask

  task automatic test_simultaneous;
    switches = 6'h05;
    nc_cnt   = 0;
    uf_cnt   = 0;
    press(1'b1, 1'b1, 8);
    checks++;
    if (number !== 6'h05) begin
      errors++;
      $display("FAIL both_value: got %h want 05", number);
    end
    checks++;
    if (uf_cnt !== 0) begin
      errors++;
      $display("FAIL both_uf: got %0d want 0", uf_cnt);
    end
    checks++;
    if (nc_cnt !== 1) begin
      errors++;
      $display("FAIL both_pulses: got %0d want 1", nc_cnt);
    end
  endtask

  task automatic test_reset_mid;
    nc_cnt  = 0;
    btn_dec = 1'b1;
    tick(4);
    reset = 1'b0;
    #3;
    checks++;
    if (number !== 6'h13) begin
      errors++;
      $display("FAIL async_reset: got %h want 13", number);
    end
    btn_dec = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(15);
    checks++;
    if (number !== 6'h13) begin
      errors++;
      $display("FAIL stale_dec: got %h want 13", number);
    end
    checks++;
    if (nc_cnt !== 0) begin
      errors++;
      $display("FAIL stale_pulses: got %0d want 0", nc_cnt);
    end
  endtask

  initial begin
    reset    = 1'b0;
    switches = 6'h00;
    btn_load = 1'b0;
    btn_dec  = 1'b0;
    test_reset();
    test_load();
    test_bounce();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
